fifo_sync_n: RTL

Parametrised synchronous FIFO that replaces the fixed-depth counter/mux/demux FIFO skeleton with one complete block. It covers storage, read/write pointers, occupancy count, full/pending flags, a programmable almost-full threshold, and sticky overflow/underflow error flags. It sits between a producer that asserts push and a consumer that asserts pop, in a single clock domain. The read side is show-ahead: the head entry is always visible on Dout_n.

---
 rtl/fifo_sync_n.sv | 87 ++++++++
 1 files changed

// File: rtl/fifo_sync_n.sv
// fifo_sync_n: parametrised single-clock FIFO with show-ahead read port,
// occupancy count, almost-full threshold and sticky overflow/underflow flags.
module fifo_sync_n #(
    parameter int bits  = 8,
    parameter int depth = 8,
    parameter int af_th = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [bits-1:0]            Din_n,
    output logic [bits-1:0]            Dout_n,
    output logic                       full,
    output logic                       pndng,
    output logic                       almost_full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    logic [bits-1:0] mem_q [depth];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            push_ok, pop_ok;

    // Flags decoded from the registered count; head entry gated so empty reads 0.
    always_comb begin
        full        = (count_q == CW'(depth));
        pndng       = (count_q != '0);
        almost_full = (count_q >= CW'(af_th));
        count       = count_q;
        overflow    = ovf_q;
        underflow   = udf_q;
        Dout_n      = pndng ? mem_q[rd_ptr_q] : '0;
    end

    // Accept decisions and next-state; a full FIFO still takes a push when a pop frees the head slot.
    always_comb begin
        push_ok  = push & (~full | pop);
        pop_ok   = pop & pndng;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push & ~push_ok);
        udf_d    = udf_q | (pop & ~pop_ok);
        if (push_ok)
            wr_ptr_d = (wr_ptr_q == PW'(depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop_ok)
            rd_ptr_d = (rd_ptr_q == PW'(depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset; reset discards any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage write; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem_q[wr_ptr_q] <= Din_n;
    end

endmodule
